// File: rtl/alu_arbiter.sv
// Two-port arbiter that serialises ALU operations from two requesters onto one shared ALU.
// Each transaction takes three cycles (grant, issue, capture) and reports results through shared registers.
module alu_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [2:0] op0,
  input  logic [2:0] op1,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] result,
  output logic [3:0] res_flags,
  output logic       busy,
  output logic [2:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_en_out,
  input  logic [7:0] alu_out,
  input  logic [3:0] alu_flags
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

  state_t state;
  logic   last;   // port granted most recently
  logic   port;   // port owning the transaction in flight
  logic   win;

  // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
  always_comb begin
    win = 1'b0;
    if (FIXED_PRIORITY)
      win = !req0;
    else if (req0 && req1)
      win = !last;
    else
      win = req1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last       <= 1'b1;
      port       <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      busy       <= 1'b0;
      alu_en_out <= 1'b0;
      result     <= 8'h00;
      res_flags  <= 4'h0;
      alu_op     <= 3'b000;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            state  <= ISSUE;
            busy   <= 1'b1;
            port   <= win;
            last   <= win;
            gnt0   <= !win;
            gnt1   <= win;
            // The ALU operand registers double as the transaction's private copy of op/a/b.
            alu_op <= win ? op1 : op0;
            alu_a  <= win ? a1  : a0;
            alu_b  <= win ? b1  : b0;
          end
        end
        ISSUE: begin
          state      <= CAPTURE;
          alu_en_out <= 1'b1;
        end
        CAPTURE: begin
          state      <= IDLE;
          busy       <= 1'b0;
          alu_en_out <= 1'b0;
          result     <= alu_out;
          res_flags  <= alu_flags;
          done0      <= !port;
          done1      <= port;
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          alu_en_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a behavioural registered ALU sits behind each arbiter instance,
// one instance round-robin and one fixed-priority; directed transactions with hand-computed results.
module tb_alu_arbiter;

  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_OR = 3'b010, OP_CMP = 3'b101;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [2:0] op0 = '0, op1 = '0;
  logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic       gnt0, gnt1, done0, done1, busy, alu_en_out;
  logic [7:0] result, alu_a, alu_b, alu_out;
  logic [3:0] res_flags, alu_flags;
  logic [2:0] alu_op;

  logic       fp_req0 = 1'b0, fp_req1 = 1'b0;
  logic       fp_gnt0, fp_gnt1, fp_done0, fp_done1, fp_busy, fp_en;
  logic [7:0] fp_result, fp_a, fp_b, fp_alu_out;
  logic [3:0] fp_flags, fp_alu_flags;
  logic [2:0] fp_op;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.FIXED_PRIORITY(1'b0)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .res_flags(res_flags), .busy(busy), .alu_op(alu_op), .alu_a(alu_a),
    .alu_b(alu_b), .alu_en_out(alu_en_out), .alu_out(alu_out), .alu_flags(alu_flags)
  );

  alu_arbiter #(.FIXED_PRIORITY(1'b1)) dut_fp (
    .clk(clk), .reset(reset), .req0(fp_req0), .req1(fp_req1), .op0(OP_ADD), .op1(OP_OR),
    .a0(8'h01), .b0(8'h01), .a1(8'h0F), .b1(8'hF0), .gnt0(fp_gnt0), .gnt1(fp_gnt1),
    .done0(fp_done0), .done1(fp_done1), .result(fp_result), .res_flags(fp_flags), .busy(fp_busy),
    .alu_op(fp_op), .alu_a(fp_a), .alu_b(fp_b), .alu_en_out(fp_en), .alu_out(fp_alu_out),
    .alu_flags(fp_alu_flags)
  );

  // Returns {C, O, flag_value[7:0], result[7:0]}; cmp reports a on the bus but flags a-b.
  function automatic logic [17:0] alu_calc(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r, v;
    logic       c, o;
    s = '0; r = '0; v = '0; c = 1'b0; o = 1'b0;
    case (op)
      3'b000: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; v = r; c = s[8]; o = (a[7] == b[7]) && (r[7] != a[7]); end
      3'b001: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; v = r; c = s[8]; o = (a[7] != b[7]) && (r[7] != a[7]); end
      3'b010: begin r = a | b; v = r; end
      3'b011: begin r = a & b; v = r; end
      3'b100: begin r = ~a; v = r; end
      3'b101: begin s = {1'b0, a} - {1'b0, b}; r = a; v = s[7:0]; c = s[8]; o = (a[7] != b[7]) && (v[7] != a[7]); end
      3'b110: begin r = a >> 1; v = r; c = a[0]; end
      default: begin r = a << 1; v = r; c = a[7]; end
    endcase
    return {c, o, v, r};
  endfunction

  logic [17:0] alu_q = '0, fp_alu_q = '0;
  always @(posedge clk) begin
    alu_q    <= alu_calc(alu_op, alu_a, alu_b);
    fp_alu_q <= alu_calc(fp_op, fp_a, fp_b);
  end
  assign alu_out      = alu_en_out ? alu_q[7:0] : 8'h00;
  assign alu_flags    = {alu_q[17], alu_q[15], alu_q[16], alu_q[15:8] == 8'h00};
  assign fp_alu_out   = fp_en ? fp_alu_q[7:0] : 8'h00;
  assign fp_alu_flags = {fp_alu_q[17], fp_alu_q[15], fp_alu_q[16], fp_alu_q[15:8] == 8'h00};

  // Per-cycle invariants on both instances.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if ((gnt0 && gnt1) || (done0 && done1) || (alu_en_out && !busy)) begin
        errors++;
        $display("FAIL invariant t=%0t gnt=%b%b done=%b%b en=%b busy=%b required no overlap and en only while busy",
                 $time, gnt0, gnt1, done0, done1, alu_en_out, busy);
      end
      checks++;
      if ((fp_gnt0 && fp_gnt1) || (fp_done0 && fp_done1) || (fp_en && !fp_busy)) begin
        errors++;
        $display("FAIL fp_invariant t=%0t gnt=%b%b done=%b%b en=%b busy=%b", $time,
                 fp_gnt0, fp_gnt1, fp_done0, fp_done1, fp_en, fp_busy);
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({gnt0, gnt1, done0, done1, busy, alu_en_out, result, res_flags, alu_op, alu_a, alu_b} !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b%b done=%b%b busy=%b en=%b res=%h flg=%h op=%h a=%h b=%h, all zero required",
               gnt0, gnt1, done0, done1, busy, alu_en_out, result, res_flags, alu_op, alu_a, alu_b);
    end
    checks++;
    if ({fp_gnt0, fp_gnt1, fp_done0, fp_done1, fp_busy, fp_en, fp_result, fp_flags} !== 18'd0) begin
      errors++;
      $display("FAIL fp_reset_outputs got %b required all zero",
               {fp_gnt0, fp_gnt1, fp_done0, fp_done1, fp_busy, fp_en, fp_result, fp_flags});
    end
    reset = 1'b0;
  endtask

  // One full transaction on one port, starting from IDLE at a negedge.
  task automatic run_op(input string name, input logic p, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp_res, input logic [3:0] exp_flg);
    if (!p) begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
    else    begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
    step();
    checks++;
    if ({gnt0, gnt1, busy, alu_en_out, alu_op, alu_a, alu_b} !== {!p, p, 1'b1, 1'b0, op, a, b}) begin
      errors++;
      $display("FAIL %s_grant got gnt=%b%b busy=%b en=%b op=%b a=%h b=%h required gnt=%b%b busy=1 en=0 op=%b a=%h b=%h",
               name, gnt0, gnt1, busy, alu_en_out, alu_op, alu_a, alu_b, !p, p, op, a, b);
    end
    // Requester releases and scrambles its operands; the transaction must not notice.
    if (!p) begin req0 = 1'b0; op0 = ~op; a0 = ~a; b0 = ~b; end
    else    begin req1 = 1'b0; op1 = ~op; a1 = ~a; b1 = ~b; end
    step();
    checks++;
    if ({gnt0, gnt1, done0, done1, busy, alu_en_out, alu_op, alu_a, alu_b} !== {4'b0000, 2'b11, op, a, b}) begin
      errors++;
      $display("FAIL %s_capture got gnt=%b%b done=%b%b busy=%b en=%b op=%b a=%h b=%h required en=1 op=%b a=%h b=%h",
               name, gnt0, gnt1, done0, done1, busy, alu_en_out, alu_op, alu_a, alu_b, op, a, b);
    end
    step();
    checks++;
    if ({done0, done1, gnt0, gnt1, busy, alu_en_out, result, res_flags} !== {!p, p, 4'b0000, exp_res, exp_flg}) begin
      errors++;
      $display("FAIL %s_done got done=%b%b gnt=%b%b busy=%b en=%b result=%h flags=%b required done=%b%b result=%h flags=%b",
               name, done0, done1, gnt0, gnt1, busy, alu_en_out, result, res_flags, !p, p, exp_res, exp_flg);
    end
    step();
    checks++;
    if ({done0, done1, busy, result, res_flags} !== {3'b000, exp_res, exp_flg}) begin
      errors++;
      $display("FAIL %s_hold got done=%b%b busy=%b result=%h flags=%b required done=00 busy=0 result=%h flags=%b",
               name, done0, done1, busy, result, res_flags, exp_res, exp_flg);
    end
  endtask

  task automatic test_add();
    run_op("add", 1'b0, OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b0110);
  endtask

  task automatic test_sub();
    run_op("sub", 1'b1, OP_SUB, 8'h00, 8'h01, 8'hFF, 4'b1100);
  endtask

  task automatic test_cmp();
    run_op("cmp", 1'b0, OP_CMP, 8'h55, 8'h55, 8'h55, 4'b0001);
  endtask

  task automatic test_withdraw();
    int seen;
    seen = 0;
    req0 = 1'b1; op0 = OP_ADD; a0 = 8'h01; b0 = 8'h02;
    step();
    req0 = 1'b0;
    req1 = 1'b1; op1 = OP_SUB; a1 = 8'h09; b1 = 8'h01;
    step();
    req1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (gnt1 || done1) seen++;
    end
    checks++;
    if (seen !== 0 || result !== 8'h03) begin
      errors++;
      $display("FAIL withdraw got port1 activity=%0d result=%h required 0 and result=03", seen, result);
    end
  endtask

  task automatic test_reset_capture();
    req0 = 1'b1; op0 = OP_ADD; a0 = 8'h03; b0 = 8'h04;
    step();
    req0 = 1'b0;
    step();
    checks++;
    if (alu_en_out !== 1'b1) begin
      errors++;
      $display("FAIL rst_cap_phase got en=%b required 1", alu_en_out);
    end
    reset = 1'b1;
    step();
    checks++;
    if ({done0, done1, gnt0, gnt1, busy, alu_en_out, result, res_flags} !== 18'd0) begin
      errors++;
      $display("FAIL rst_cap_abort got done=%b%b gnt=%b%b busy=%b en=%b result=%h flags=%b required all zero",
               done0, done1, gnt0, gnt1, busy, alu_en_out, result, res_flags);
    end
    reset = 1'b0;
    step();
    checks++;
    if ({done0, done1, busy} !== 3'b000) begin
      errors++;
      $display("FAIL rst_cap_no_done got done=%b%b busy=%b required 000", done0, done1, busy);
    end
    run_op("after_rst", 1'b0, OP_ADD, 8'h03, 8'h04, 8'h07, 4'b0000);
  endtask

  task automatic test_back_to_back();
    logic [3:0] order, fp_gnts;
    int         n, last_c, bad_gap, bad_res, fp_n1, fp_bad;
    n = 0; last_c = -3; bad_gap = 0; bad_res = 0; fp_n1 = 0; fp_bad = 0;
    order = '0; fp_gnts = '0;
    do_reset();
    req0 = 1'b1; op0 = OP_ADD; a0 = 8'h10; b0 = 8'h20;
    req1 = 1'b1; op1 = OP_OR;  a1 = 8'h0F; b1 = 8'hF0;
    fp_req0 = 1'b1; fp_req1 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      if (gnt0 || gnt1) begin
        if (n < 4) order[n] = gnt1;
        if (c - last_c != 3) bad_gap++;
        last_c = c;
        n++;
      end
      if (done0 && {result, res_flags} !== {8'h30, 4'b0000}) bad_res++;
      if (done1 && {result, res_flags} !== {8'hFF, 4'b0100}) bad_res++;
      if (fp_gnt0 && c % 3 == 0) fp_gnts[c / 3] = 1'b1;
      if (fp_gnt1) fp_n1++;
      if (fp_done0 && {fp_result, fp_flags} !== {8'h02, 4'b0000}) fp_bad++;
    end
    req0 = 1'b0; req1 = 1'b0; fp_req0 = 1'b0; fp_req1 = 1'b0;
    checks++;
    if (n !== 4 || order !== 4'b1010) begin
      errors++;
      $display("FAIL rr_order got %0d grants order(lsb first)=%b required 4 grants order=1010", n, order);
    end
    checks++;
    if (bad_gap !== 0) begin
      errors++;
      $display("FAIL rr_spacing got %0d grants not 3 cycles apart required 0", bad_gap);
    end
    checks++;
    if (bad_res !== 0) begin
      errors++;
      $display("FAIL rr_results got %0d wrong done results required 0", bad_res);
    end
    checks++;
    if (fp_gnts !== 4'b1111 || fp_n1 !== 0 || fp_bad !== 0) begin
      errors++;
      $display("FAIL fixed_priority got port0 grant slots=%b port1 grants=%0d bad results=%0d required 1111, 0, 0",
               fp_gnts, fp_n1, fp_bad);
    end
    step();
    step();
    checks++;
    if ({gnt0, gnt1, busy, fp_gnt0, fp_gnt1, fp_busy} !== 6'd0) begin
      errors++;
      $display("FAIL rr_drain got gnt=%b%b busy=%b fp gnt=%b%b busy=%b required all zero",
               gnt0, gnt1, busy, fp_gnt0, fp_gnt1, fp_busy);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_cmp();
    test_withdraw();
    test_reset_capture();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
